// File: rtl/line_cmd_master_if.sv
// Command handshake plus Avalon-MM register-bus signals between the line command
// master and its partners (command source and accelerator slave).
interface line_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x0;
  logic [7:0]  cmd_y0;
  logic [8:0]  cmd_x1;
  logic [7:0]  cmd_y1;
  logic [2:0]  cmd_color;
  logic [2:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
    output cmd_ready,
    output address, chipselect, read, write, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
    input  cmd_ready,
    input  address, chipselect, read, write, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/line_cmd_master.sv
// Avalon-MM master that programs the line-drawing accelerator: Mode once after reset,
// then per command start/end/colour/Go, optionally gated by Status polling.
module line_cmd_master #(
  parameter int POLL_MODE  = 0,
  parameter int POLL_LIMIT = 1024
) (
  input  logic                CLOCK_50,
  input  logic                Reset,
  line_cmd_master_if.master   bus,
  output logic                busy,
  output logic [15:0]         line_count,
  output logic                timeout
);
  localparam int CW = $clog2(POLL_LIMIT + 1);

  localparam logic [2:0] ADDR_MODE   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_GO     = 3'd2;
  localparam logic [2:0] ADDR_START  = 3'd3;
  localparam logic [2:0] ADDR_END    = 3'd4;
  localparam logic [2:0] ADDR_COLOR  = 3'd5;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_POLL_RD, S_POLL_CHK, S_WR_START, S_WR_END, S_WR_COLOR, S_WR_GO
  } state_t;

  state_t        state_q, state_d, next_state;
  logic [2:0]    address_q, address_d, req_addr;
  logic [31:0]   writedata_q, writedata_d, req_data;
  logic          read_q, read_d, write_q, write_d, req_rd, is_xfer;
  logic          chipselect_q, chipselect_d;
  logic          cmd_ready_q, cmd_ready_d, busy_q, busy_d, timeout_q, timeout_d;
  logic [15:0]   line_count_q, line_count_d;
  logic [CW-1:0] poll_cnt_q, poll_cnt_d;
  logic [8:0]    x0_q, x0_d, x1_q, x1_d;
  logic [7:0]    y0_q, y0_d, y1_q, y1_d;
  logic [2:0]    color_q, color_d;
  logic          readdata_unused;

  // Only the ready bit of Status matters.
  assign readdata_unused = ^bus.readdata[31:1];

  always_comb begin
    state_d      = state_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    read_d       = read_q;
    write_d      = write_q;
    line_count_d = line_count_q;
    timeout_d    = timeout_q;
    poll_cnt_d   = poll_cnt_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    color_d      = color_q;
    req_addr     = ADDR_MODE;
    req_data     = 32'd0;
    req_rd       = 1'b0;
    is_xfer      = 1'b1;
    next_state   = state_q;

    case (state_q)
      S_INIT:     begin req_addr = ADDR_MODE;   req_data = 32'(POLL_MODE); next_state = S_IDLE; end
      S_POLL_RD:  begin req_addr = ADDR_STATUS; req_rd = 1'b1;             next_state = S_POLL_CHK; end
      S_WR_START: begin req_addr = ADDR_START;  req_data = {15'b0, y0_q, x0_q}; next_state = S_WR_END; end
      S_WR_END:   begin req_addr = ADDR_END;    req_data = {15'b0, y1_q, x1_q}; next_state = S_WR_COLOR; end
      S_WR_COLOR: begin req_addr = ADDR_COLOR;  req_data = {29'b0, color_q};    next_state = S_WR_GO; end
      S_WR_GO:    begin req_addr = ADDR_GO;     req_data = 32'h1;              next_state = S_IDLE; end
      S_IDLE: begin
        is_xfer = 1'b0;
        if (bus.cmd_valid && cmd_ready_q) begin
          x0_d       = bus.cmd_x0;
          y0_d       = bus.cmd_y0;
          x1_d       = bus.cmd_x1;
          y1_d       = bus.cmd_y1;
          color_d    = bus.cmd_color;
          poll_cnt_d = '0;
          state_d    = (POLL_MODE != 0) ? S_POLL_RD : S_WR_START;
        end
      end
      S_POLL_CHK: begin
        is_xfer = 1'b0;
        if (bus.readdata[0]) begin
          state_d = S_WR_START;
        end else if (poll_cnt_q == CW'(POLL_LIMIT)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d = S_POLL_RD;
        end
      end
      default: begin
        is_xfer = 1'b0;
        state_d = S_INIT;
      end
    endcase

    // Strobe rises the cycle after entry; it falls (and the state moves) on acceptance.
    if (is_xfer) begin
      if (!(read_q || write_q)) begin
        address_d   = req_addr;
        writedata_d = req_data;
        read_d      = req_rd;
        write_d     = !req_rd;
      end else if (!bus.waitrequest) begin
        read_d  = 1'b0;
        write_d = 1'b0;
        state_d = next_state;
        if (state_q == S_POLL_RD) poll_cnt_d   = poll_cnt_q + CW'(1);
        if (state_q == S_WR_GO)   line_count_d = line_count_q + 16'd1;
      end
    end

    chipselect_d = ~(read_d | write_d);
    cmd_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q      <= S_INIT;
      address_q    <= '0;
      writedata_q  <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      chipselect_q <= 1'b1;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b1;
      timeout_q    <= 1'b0;
      line_count_q <= '0;
      poll_cnt_q   <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      color_q      <= '0;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      read_q       <= read_d;
      write_q      <= write_d;
      chipselect_q <= chipselect_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      line_count_q <= line_count_d;
      poll_cnt_q   <= poll_cnt_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      color_q      <= color_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.address    = address_q;
  assign bus.writedata  = writedata_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.chipselect = chipselect_q;
  assign busy           = busy_q;
  assign line_count     = line_count_q;
  assign timeout        = timeout_q;
endmodule

// File: tb/tb_line_cmd_master.sv
// Directed bench: a stall-mode instance and a poll-mode instance (POLL_LIMIT=4),
// each with a small Avalon slave model that logs every accepted transfer.
module tb_line_cmd_master;
  typedef struct packed {
    logic        rd;
    logic [2:0]  a;
    logic [31:0] d;
  } xfer_t;

  typedef struct {
    logic [8:0]  x0;
    logic [7:0]  y0;
    logic [8:0]  x1;
    logic [7:0]  y1;
    logic [2:0]  color;
    logic [31:0] exp_start;
    logic [31:0] exp_end;
    logic [31:0] exp_color;
  } vec_t;

  logic clk = 1'b0;
  logic rst_s, rst_p;
  logic busy_s, busy_p, to_s, to_p;
  logic [15:0] lc_s, lc_p;

  int tests = 0;
  int fails = 0;
  int exp_lc_s = 0;
  int exp_lc_p = 0;

  xfer_t log_s[$];
  xfer_t log_p[$];
  logic [31:0] status_q[$];
  vec_t vecs[3];

  line_cmd_master_if bus_s();
  line_cmd_master_if bus_p();

  line_cmd_master #(.POLL_MODE(0), .POLL_LIMIT(1024)) u_stall (
    .CLOCK_50(clk), .Reset(rst_s), .bus(bus_s),
    .busy(busy_s), .line_count(lc_s), .timeout(to_s)
  );

  line_cmd_master #(.POLL_MODE(1), .POLL_LIMIT(4)) u_poll (
    .CLOCK_50(clk), .Reset(rst_p), .bus(bus_p),
    .busy(busy_p), .line_count(lc_p), .timeout(to_p)
  );

  always #10 clk = ~clk;

  assign bus_s.readdata = 32'h0;

  // Slave models: record accepted transfers; poll slave returns queued Status words one cycle later.
  always @(posedge clk) begin
    if (!rst_s && (bus_s.write || bus_s.read) && !bus_s.waitrequest)
      log_s.push_back({bus_s.read, bus_s.address, bus_s.read ? 32'h0 : bus_s.writedata});
  end

  always @(posedge clk) begin
    logic [31:0] v;
    if (rst_p) begin
      bus_p.readdata <= 32'h0;
    end else if ((bus_p.write || bus_p.read) && !bus_p.waitrequest) begin
      log_p.push_back({bus_p.read, bus_p.address, bus_p.read ? 32'h0 : bus_p.writedata});
      if (bus_p.read) begin
        v = (status_q.size() > 0) ? status_q.pop_front() : 32'h0;
        bus_p.readdata <= v;
      end
    end
  end

  function automatic xfer_t mk(input logic rd, input logic [2:0] a, input logic [31:0] d);
    mk = {rd, a, d};
  endfunction

  function automatic logic rdy(input bit p);
    return p ? bus_p.cmd_ready : bus_s.cmd_ready;
  endfunction

  function automatic logic bsy(input bit p);
    return p ? busy_p : busy_s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: wait bound expired, got timeout, expected event", name);
  endtask

  task automatic chk_entry(input bit p, input int idx, input string name, input xfer_t exp);
    xfer_t act;
    int sz;
    sz = p ? log_p.size() : log_s.size();
    if (idx < sz) act = p ? log_p[idx] : log_s[idx];
    else          act = '1;
    chk(name, 64'(act), 64'(exp));
  endtask

  task automatic wait_idle(input bit p, input int lim, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rdy(p) && !bsy(p)) && n < lim);
    if (!(rdy(p) && !bsy(p))) bound_fail(name);
  endtask

  task automatic wait_write(input bit p, input logic [2:0] a, input int lim, input string name);
    int n = 0;
    logic hit;
    do begin
      @(negedge clk);
      n++;
      hit = p ? (bus_p.write && bus_p.address == a) : (bus_s.write && bus_s.address == a);
    end while (!hit && n < lim);
    if (!hit) bound_fail(name);
  endtask

  task automatic issue(input bit p, input vec_t v);
    bus_s.cmd_x0 = v.x0; bus_s.cmd_y0 = v.y0; bus_s.cmd_x1 = v.x1;
    bus_s.cmd_y1 = v.y1; bus_s.cmd_color = v.color;
    bus_p.cmd_x0 = v.x0; bus_p.cmd_y0 = v.y0; bus_p.cmd_x1 = v.x1;
    bus_p.cmd_y1 = v.y1; bus_p.cmd_color = v.color;
    if (p) bus_p.cmd_valid = 1'b1;
    else   bus_s.cmd_valid = 1'b1;
    @(negedge clk);
    bus_s.cmd_valid = 1'b0;
    bus_p.cmd_valid = 1'b0;
  endtask

  task automatic chk_writes(input bit p, input int base, input vec_t v, input string tag);
    chk_entry(p, base + 0, {tag, " start"}, mk(1'b0, 3'd3, v.exp_start));
    chk_entry(p, base + 1, {tag, " end"},   mk(1'b0, 3'd4, v.exp_end));
    chk_entry(p, base + 2, {tag, " color"}, mk(1'b0, 3'd5, v.exp_color));
    chk_entry(p, base + 3, {tag, " go"},    mk(1'b0, 3'd2, 32'h1));
  endtask

  initial begin
    int n4;
    vecs[0] = '{x0: 9'd10, y0: 8'd20,  x1: 9'd300, y1: 8'd200, color: 3'd5,
                exp_start: 32'h0000280A, exp_end: 32'h0001912C, exp_color: 32'h5};
    vecs[1] = '{x0: 9'd0,  y0: 8'd0,   x1: 9'd511, y1: 8'd255, color: 3'd7,
                exp_start: 32'h00000000, exp_end: 32'h0001FFFF, exp_color: 32'h7};
    vecs[2] = '{x0: 9'd1,  y0: 8'd1,   x1: 9'd256, y1: 8'd128, color: 3'd0,
                exp_start: 32'h00000201, exp_end: 32'h00010100, exp_color: 32'h0};

    rst_s = 1'b1; rst_p = 1'b1;
    bus_s.waitrequest = 1'b0; bus_p.waitrequest = 1'b0;
    bus_s.cmd_valid = 1'b0;   bus_p.cmd_valid = 1'b0;
    bus_s.cmd_x0 = '0; bus_s.cmd_y0 = '0; bus_s.cmd_x1 = '0; bus_s.cmd_y1 = '0; bus_s.cmd_color = '0;
    bus_p.cmd_x0 = '0; bus_p.cmd_y0 = '0; bus_p.cmd_x1 = '0; bus_p.cmd_y1 = '0; bus_p.cmd_color = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst address",    64'(bus_s.address), 64'd0);
    chk("rst strobes",    64'({bus_s.read, bus_s.write}), 64'd0);
    chk("rst chipselect", 64'(bus_s.chipselect), 64'd1);
    chk("rst writedata",  64'(bus_s.writedata), 64'd0);
    chk("rst ready/busy", 64'({bus_s.cmd_ready, busy_s}), 64'b01);
    chk("rst lc/timeout", 64'({lc_s, to_s}), 64'd0);
    rst_s = 1'b0; rst_p = 1'b0;
    log_s.delete(); log_p.delete();

    wait_idle(0, 20, "init stall");
    wait_idle(1, 20, "init poll");
    chk("init stall count", 64'(log_s.size()), 64'd1);
    chk_entry(0, 0, "init stall mode write", mk(1'b0, 3'd0, 32'h0));
    chk_entry(1, 0, "init poll mode write",  mk(1'b0, 3'd0, 32'h1));
    chk("idle ready/cs", 64'({bus_s.cmd_ready, bus_s.chipselect}), 64'b11);
    chk("idle lc", 64'(lc_s), 64'd0);

    // Table-driven stall-mode commands
    for (int i = 0; i < 3; i++) begin
      log_s.delete();
      issue(0, vecs[i]);
      wait_idle(0, 100, $sformatf("vec%0d idle", i));
      exp_lc_s++;
      chk($sformatf("vec%0d count", i), 64'(log_s.size()), 64'd4);
      chk_writes(0, 0, vecs[i], $sformatf("vec%0d", i));
      chk($sformatf("vec%0d line_count", i), 64'(lc_s), 64'(exp_lc_s));
      chk($sformatf("vec%0d ready", i), 64'(bus_s.cmd_ready), 64'd1);
    end

    // waitrequest held 6 cycles on the end-point write
    log_s.delete();
    issue(0, vecs[0]);
    wait_write(0, 3'd4, 50, "stall addr4 seen");
    bus_s.waitrequest = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("stall hold c%0d", c),
          64'({bus_s.address, bus_s.writedata, bus_s.write, bus_s.chipselect}),
          64'({3'd4, 32'h0001912C, 1'b1, 1'b0}));
    end
    bus_s.waitrequest = 1'b0;
    wait_idle(0, 100, "stall idle");
    exp_lc_s++;
    n4 = 0;
    foreach (log_s[k]) if (log_s[k].a == 3'd4) n4++;
    chk("stall addr4 transfers", 64'(n4), 64'd1);
    chk_writes(0, 0, vecs[0], "stall");
    chk("stall line_count", 64'(lc_s), 64'(exp_lc_s));

    // Poll mode: Status 0, 0, 1
    log_p.delete();
    status_q.push_back(32'h0); status_q.push_back(32'h0); status_q.push_back(32'h1);
    issue(1, vecs[0]);
    wait_idle(1, 200, "poll idle");
    exp_lc_p++;
    chk("poll count", 64'(log_p.size()), 64'd7);
    for (int k = 0; k < 3; k++) chk_entry(1, k, $sformatf("poll read%0d", k), mk(1'b1, 3'd1, 32'h0));
    chk_writes(1, 3, vecs[0], "poll");
    chk("poll line_count", 64'(lc_p), 64'(exp_lc_p));
    chk("poll timeout", 64'(to_p), 64'd0);

    // Poll timeout: Status stuck at 0
    log_p.delete();
    status_q.delete();
    issue(1, vecs[1]);
    wait_idle(1, 200, "tmo idle");
    chk("tmo count", 64'(log_p.size()), 64'd4);
    for (int k = 0; k < 4; k++) chk_entry(1, k, $sformatf("tmo read%0d", k), mk(1'b1, 3'd1, 32'h0));
    chk("tmo flag", 64'(to_p), 64'd1);
    chk("tmo line_count", 64'(lc_p), 64'(exp_lc_p));

    // Next command after timeout completes; flag stays set
    log_p.delete();
    status_q.push_back(32'h1);
    issue(1, vecs[2]);
    wait_idle(1, 200, "post-tmo idle");
    exp_lc_p++;
    chk("post-tmo count", 64'(log_p.size()), 64'd5);
    chk_entry(1, 0, "post-tmo read", mk(1'b1, 3'd1, 32'h0));
    chk_writes(1, 1, vecs[2], "post-tmo");
    chk("post-tmo line_count", 64'(lc_p), 64'(exp_lc_p));
    chk("post-tmo flag", 64'(to_p), 64'd1);

    // Reset during a stalled colour write
    issue(0, vecs[1]);
    wait_write(0, 3'd5, 50, "rst addr5 seen");
    bus_s.waitrequest = 1'b1;
    repeat (2) @(negedge clk);
    rst_s = 1'b1;
    log_s.delete();
    @(negedge clk);
    chk("midrst write/cs", 64'({bus_s.write, bus_s.chipselect}), 64'b01);
    chk("midrst line_count", 64'(lc_s), 64'd0);
    chk("midrst busy", 64'(busy_s), 64'd1);
    rst_s = 1'b0;
    bus_s.waitrequest = 1'b0;
    wait_idle(0, 20, "midrst idle");
    chk("midrst count", 64'(log_s.size()), 64'd1);
    chk_entry(0, 0, "midrst init write", mk(1'b0, 3'd0, 32'h0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
